// File: rtl/shift_sequencer_if.sv
// Command channel between a host and the shift sequencer.
// The master drives the command fields and cmd_valid; the slave returns cmd_ready.
interface shift_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic             cmd_dir;
    logic             cmd_fill;
    logic [CNT_W-1:0] cmd_count;
    logic [WIDTH-1:0] cmd_data;

    modport master (
        output cmd_valid, cmd_op, cmd_dir, cmd_fill, cmd_count, cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_dir, cmd_fill, cmd_count, cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/shift_sequencer.sv
// Sequences LOAD / SHIFT / ROTATE commands onto a universal shift register's mode and serial inputs.
// Latency: LOAD done 2 cycles after accept, shift/rotate N+1, zero count 1.
// Backpressure: cmd_ready only in IDLE; commands offered while busy are not queued.
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                Clk,
    input  logic                Reset,
    shift_sequencer_if.slave    cmd,
    input  logic [WIDTH-1:0]    Result,
    output logic [1:0]          LR,
    output logic [WIDTH-1:0]    Data,
    output logic                Left_Input,
    output logic                Right_Input,
    output logic                busy,
    output logic                done
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'd0;
    localparam logic [1:0] OP_SHR  = 2'd1;
    localparam logic [1:0] OP_ROT  = 2'd3;

    localparam logic [1:0] LR_HOLD  = 2'd0;
    localparam logic [1:0] LR_RIGHT = 2'd1;
    localparam logic [1:0] LR_LEFT  = 2'd2;
    localparam logic [1:0] LR_LOAD  = 2'd3;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] eff_cnt;
    logic [1:0]       op_q;
    logic             dir_q;
    logic             fill_q;
    logic [1:0]       lr_d;
    logic             accept;
    logic             in_shift;
    logic             is_rot;

    function automatic logic [1:0] shift_lr(input logic [1:0] op, input logic dir);
        if (op == OP_SHR || (op == OP_ROT && !dir))
            return LR_RIGHT;
        return LR_LEFT;
    endfunction

    assign cmd.cmd_ready = (state_q == S_IDLE);
    assign accept        = cmd.cmd_valid && (state_q == S_IDLE);
    assign eff_cnt       = (cmd.cmd_count > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : cmd.cmd_count;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lr_d    = LR_HOLD;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (cmd.cmd_op == OP_LOAD) begin
                        state_d = S_LOAD;
                        lr_d    = LR_LOAD;
                    end else if (eff_cnt == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SHIFT;
                        cnt_d   = eff_cnt;
                        lr_d    = shift_lr(cmd.cmd_op, cmd.cmd_dir);
                    end
                end
            end
            S_LOAD: state_d = S_DONE;
            S_SHIFT: begin
                cnt_d = cnt_q - 1'b1;
                // LR is registered, so it must drop on the edge that ends the last shift cycle
                if (cnt_q == CNT_W'(1))
                    state_d = S_DONE;
                else
                    lr_d = shift_lr(op_q, dir_q);
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= 2'd0;
            dir_q   <= 1'b0;
            fill_q  <= 1'b0;
            Data    <= '0;
            LR      <= LR_HOLD;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            LR      <= lr_d;
            done    <= (state_d == S_DONE);
            busy    <= (state_d != S_IDLE);
            if (accept) begin
                op_q   <= cmd.cmd_op;
                dir_q  <= cmd.cmd_dir;
                fill_q <= cmd.cmd_fill;
                if (cmd.cmd_op == OP_LOAD)
                    Data <= cmd.cmd_data;
            end
        end
    end

    // Rotate feeds the outgoing end of Result straight back in; the unused serial input stays 0.
    assign in_shift    = (state_q == S_SHIFT);
    assign is_rot      = (op_q == OP_ROT);
    assign Left_Input  = in_shift && (is_rot ? (!dir_q && Result[0])       : fill_q);
    assign Right_Input = in_shift && (is_rot ? ( dir_q && Result[WIDTH-1]) : fill_q);
endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer driving a behavioural universal shift register.
module tb_shift_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] result = 8'h00;
    logic [1:0] lr;
    logic [7:0] data;
    logic       left_input, right_input, busy, done;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;

    typedef struct {
        logic [7:0] result;
        int         latency;
        logic [1:0] lr;
        int         active;
        logic       li;
        logic       ri;
    } exp_t;
    exp_t sb[$];

    shift_sequencer_if #(.WIDTH(8), .CNT_W(4)) cif ();

    shift_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
        .Clk         (clk),
        .Reset       (rst_n),
        .cmd         (cif),
        .Result      (result),
        .LR          (lr),
        .Data        (data),
        .Left_Input  (left_input),
        .Right_Input (right_input),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Universal shift register the sequencer controls
    always @(posedge clk) begin
        case (lr)
            2'd1: result <= {left_input, result[7:1]};
            2'd2: result <= {result[6:0], right_input};
            2'd3: result <= data;
            default: result <= result;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] op, input logic dir,
                           input logic fill, input logic [3:0] count, input logic [7:0] din,
                           input logic [7:0] exp_res, input logic exp_li, input logic exp_ri,
                           input bit keep_valid, input int exp_wait,
                           output int acc_cyc, output int done_cyc);
        exp_t e;
        int   n, waited, lat, active, bad_lr;
        logic li1, ri1;
        bit   first;
        n         = (count > 4'd8) ? 8 : int'(count);
        e.result  = exp_res;
        e.latency = (op == 2'd0) ? 2 : n + 1;
        e.lr      = (op == 2'd0) ? 2'd3 : ((op == 2'd1 || (op == 2'd3 && !dir)) ? 2'd1 : 2'd2);
        e.active  = (op == 2'd0) ? 1 : n;
        e.li      = exp_li;
        e.ri      = exp_ri;
        cif.cmd_op    = op;
        cif.cmd_dir   = dir;
        cif.cmd_fill  = fill;
        cif.cmd_count = count;
        cif.cmd_data  = din;
        cif.cmd_valid = 1'b1;
        waited = 0;
        while (!cif.cmd_ready && waited < 50) begin
            tick();
            waited++;
        end
        check({tag, "_accept_wait"}, waited, exp_wait);
        tick();
        acc_cyc = cyc;
        sb.push_back(e);
        if (!keep_valid) cif.cmd_valid = 1'b0;
        lat = 1; active = 0; bad_lr = 0; first = 1'b1; li1 = 1'b0; ri1 = 1'b0;
        while (!done && lat < 50) begin
            if (lr == e.lr) begin
                active++;
                if (first) begin
                    li1 = left_input;
                    ri1 = right_input;
                    first = 1'b0;
                end
            end else if (lr != 2'd0) begin
                bad_lr++;
            end
            tick();
            lat++;
        end
        done_cyc = cyc;
        e = sb.pop_front();
        check({tag, "_latency"}, lat, e.latency);
        check({tag, "_active_cycles"}, active, e.active);
        check({tag, "_stray_lr"}, bad_lr, 0);
        check({tag, "_lr_at_done"}, lr, 2'd0);
        check({tag, "_busy_at_done"}, busy, 1'b1);
        check({tag, "_ready_at_done"}, cif.cmd_ready, 1'b0);
        check({tag, "_result"}, result, e.result);
        if (op != 2'd0 && n > 0) begin
            check({tag, "_left_input"}, li1, e.li);
            check({tag, "_right_input"}, ri1, e.ri);
        end
    endtask

    initial begin
        int a0, d0, a1, d1;
        bit saw_done;
        cif.cmd_valid = 1'b0;
        cif.cmd_op    = 2'd0;
        cif.cmd_dir   = 1'b0;
        cif.cmd_fill  = 1'b0;
        cif.cmd_count = 4'd0;
        cif.cmd_data  = 8'h00;

        #3;
        check("rst_ready", cif.cmd_ready, 1'b1);
        check("rst_lr", lr, 2'd0);
        check("rst_done", done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_data", data, 8'h00);
        #9 rst_n = 1'b1;
        tick();
        check("idle_ready", cif.cmd_ready, 1'b1);
        check("idle_busy", busy, 1'b0);
        check("idle_serial", {left_input, right_input}, 2'b00);

        run_cmd("load32", 2'd0, 1'b0, 1'b0, 4'd0, 8'b0011_0010, 8'h32, 1'b0, 1'b0, 0, 0, a0, d0);
        run_cmd("shr3", 2'd1, 1'b0, 1'b1, 4'd3, 8'h00, 8'b1110_0110, 1'b1, 1'b1, 0, 1, a0, d0);
        check("data_kept", data, 8'h32);

        run_cmd("load81", 2'd0, 1'b0, 1'b0, 4'd0, 8'h81, 8'h81, 1'b0, 1'b0, 0, 1, a0, d0);
        run_cmd("rotl1", 2'd3, 1'b1, 1'b0, 4'd1, 8'h00, 8'h03, 1'b0, 1'b1, 0, 1, a0, d0);
        run_cmd("rotr12", 2'd3, 1'b0, 1'b1, 4'd12, 8'h00, 8'h03, 1'b1, 1'b0, 0, 1, a0, d0);

        // Count 0 with cmd_valid held: the following LOAD may only be taken after done
        run_cmd("shl0", 2'd2, 1'b0, 1'b1, 4'd0, 8'h00, 8'h03, 1'b0, 1'b0, 1, 1, a0, d0);
        run_cmd("loadf0", 2'd0, 1'b0, 1'b0, 4'd0, 8'hF0, 8'hF0, 1'b0, 1'b0, 0, 1, a0, d0);
        run_cmd("shl2", 2'd2, 1'b0, 1'b0, 4'd2, 8'h00, 8'hC0, 1'b0, 1'b0, 0, 1, a1, d1);
        check("b2b_span", d1 - a0, 5);

        // Abort an 8-cycle shift right after two shifts: 0xC0 -> 0xE0 -> 0xF0
        cif.cmd_op = 2'd1; cif.cmd_dir = 1'b0; cif.cmd_fill = 1'b1;
        cif.cmd_count = 4'd8; cif.cmd_valid = 1'b1;
        tick();
        check("abort_ready_before", cif.cmd_ready, 1'b1);
        tick();
        cif.cmd_valid = 1'b0;
        check("abort_shifting", lr, 2'd1);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_lr", lr, 2'd0);
        check("abort_ready", cif.cmd_ready, 1'b1);
        check("abort_serial", {left_input, right_input}, 2'b00);
        saw_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        #3 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        check("abort_no_done", saw_done, 1'b0);
        check("abort_result_held", result, 8'hF0);
        check("abort_idle_busy", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Command-driven controller for the 8-bit universal shift register. It accepts one command per handshake and drives the register's mode code LR, parallel Data, and the serial Left_Input and Right_Input.
- It counts shift cycles and pulses done when a command completes.
- It sits between a host or FSM and the shift register, and reads the register's Result back to implement rotates.

Parameters:
- WIDTH, 8, shift register width; Data and Result are WIDTH bits.
- CNT_W, 4, width of cmd_count; must hold the value WIDTH.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-low reset (0 = in reset).
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command; high only in IDLE.
- cmd_op  input  2  0 = LOAD, 1 = SHIFT_RIGHT, 2 = SHIFT_LEFT, 3 = ROTATE.
- cmd_dir  input  1  ROTATE direction: 0 = right, 1 = left. Ignored for other ops.
- cmd_fill  input  1  serial fill bit for SHIFT_RIGHT and SHIFT_LEFT.
- cmd_count  input  CNT_W  number of shift cycles.
- cmd_data  input  WIDTH  LOAD value.
- Result  input  WIDTH  current shift register contents.
- LR  output  2  register mode: 0 = hold, 1 = shift right (Left_Input enters at MSB), 2 = shift left (Right_Input enters at LSB), 3 = parallel load.
- Data  output  WIDTH  parallel load value.
- Left_Input  output  1  serial input at MSB.
- Right_Input  output  1  serial input at LSB.
- busy  output  1  command in progress (state is not IDLE).
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (Reset = 0, asynchronous) forces the following immediately:
  - state = IDLE, LR = 0, Data = 0, done = 0, busy = 0, cmd_ready = 1;
  - shift counter = 0, latched fill = 0, latched op/dir = 0.
- Reset asserted mid-command aborts the command with no done pulse. The register holds its current contents because LR = 0.
- Handshake: a command is accepted on the rising edge where cmd_valid && cmd_ready. All cmd_* fields are latched at that edge. cmd_valid while busy is ignored and not queued.
- States are IDLE, LOAD, SHIFT and DONE.
- IDLE: LR = 0 and cmd_ready = 1. On accept the next state is chosen as follows:
  - op = LOAD goes to LOAD;
  - any shift or rotate op with effective count > 0 goes to SHIFT;
  - any shift or rotate op with count = 0 goes directly to DONE.
- Effective count = min(cmd_count, WIDTH). Counts above WIDTH saturate.
- LOAD lasts exactly 1 cycle:
  - LR = 3 and Data = latched cmd_data;
  - then go to DONE.
- SHIFT lasts exactly N cycles, where N is the effective count:
  - LR = 1 for SHIFT_RIGHT or ROTATE with dir = 0;
  - LR = 2 for SHIFT_LEFT or ROTATE with dir = 1;
  - the counter decrements each cycle, and the last cycle goes to DONE.
- DONE lasts 1 cycle: LR = 0, done = 1, busy = 1, then go to IDLE.
- Latency from the accept edge to the done pulse:
  - LOAD: 2 cycles;
  - shift or rotate: N + 1 cycles;
  - count 0: 1 cycle.
- The next command can be accepted on the cycle after done.
- Serial inputs:
  - SHIFT_RIGHT / SHIFT_LEFT: Left_Input = Right_Input = latched cmd_fill.
  - ROTATE right: Left_Input = Result[0], combinational from Result.
  - ROTATE left: Right_Input = Result[WIDTH-1], combinational from Result.
  - The unused serial input is held at 0. Outside SHIFT both serial inputs are 0.
- LR, Data, done and busy are registered. Only the rotate feedback path is combinational.
- Data keeps its last loaded value outside LOAD. It is only sampled by the register when LR = 3.

Test Plan:
- Reset = 0 then released, with no command -> cmd_ready = 1, LR = 0, done = 0, busy = 0. Asserting Reset mid-SHIFT returns to IDLE within the same cycle, with no done pulse.
- LOAD cmd_data = 8'b00110010 -> LR = 3 for one cycle, done one cycle later; Result = 8'h32.
- After LOAD 8'h32, SHIFT_RIGHT with count = 3 and fill = 1 -> LR = 1 for exactly 3 cycles, then done; Result = 8'b11100110.
- After LOAD 8'h81, ROTATE left with count = 1 -> Right_Input = 1 during the shift; Result = 8'h03. Then ROTATE right with count = 12 (saturates to 8) -> exactly 8 shift cycles; Result = 8'h03.
- Count = 0 SHIFT_LEFT -> no cycle with LR ≠ 0, done one cycle after accept. cmd_valid held high while busy -> second command accepted only on the cycle after done.
- Back-to-back commands LOAD 8'hF0, SHIFT_LEFT with count = 2 and fill = 0 -> Result = 8'hC0; total of 5 cycles from first accept to second done.
